// File: rtl/nic8_pkg.sv
// nic8 shared definitions: sequencer state type and instruction register
// field layout used by the fetch sequencer and the instruction decoder.
package nic8_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  // Instruction register layout: bit7 | dest[6:4] | bit3 | source[2:0]
  localparam int IR_BIT7     = 7;
  localparam int IR_DEST_MSB = 6;
  localparam int IR_DEST_LSB = 4;
  localparam int IR_BIT3     = 3;
  localparam int IR_SRC_MSB  = 2;
  localparam int IR_SRC_LSB  = 0;

  // Source 0 takes the operand byte that follows the opcode in ROM;
  // destination 1 writes the program counter (a jump).
  localparam logic [2:0] SRC_ROM = 3'd0;
  localparam logic [2:0] DST_PC  = 3'd1;

  function automatic logic [2:0] ir_source(input logic [7:0] ir);
    return ir[IR_SRC_MSB:IR_SRC_LSB];
  endfunction

  function automatic logic [2:0] ir_dest(input logic [7:0] ir);
    return ir[IR_DEST_MSB:IR_DEST_LSB];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer and the rest of the nic8 core:
// ROM port, decoder feedback, jump bus and front-panel run/step controls.
// The retireCount signal exists only when RETIRE_COUNT_EN is defined.
interface fetch_sequencer_if #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
);
  logic [7:0]      romData;
  logic            romReady;
  logic [PC_W-1:0] romAddr;
  logic [7:0]      ir;
  logic            irValid;
  logic            immediate;
  logic            doJump;
  logic [7:0]      busIn;
  logic            run;
  logic            stepReq;
  logic            stepAck;
  logic            halted;
  logic [PC_W-1:0] pc;
`ifdef RETIRE_COUNT_EN
  logic [CNT_W-1:0] retireCount;
`endif

  // Sequencer side
  modport master (
    input  romData, romReady, immediate, doJump, busIn, run, stepReq,
    output romAddr, ir, irValid, stepAck, halted, pc
`ifdef RETIRE_COUNT_EN
    , output retireCount
`endif
  );

  // ROM, decoder and front-panel side
  modport slave (
    output romData, romReady, immediate, doJump, busIn, run, stepReq,
    input  romAddr, ir, irValid, stepAck, halted, pc
`ifdef RETIRE_COUNT_EN
    , input retireCount
`endif
  );

endinterface

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter register: loads a jump target or advances by 0 or 1,
// wrapping modulo 2^PC_W.
module pc_counter #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            resetBar,
  input  logic            en,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] pc
);

  // PC update: jump target wins over the increment
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      pc <= PC_W'(RESET_PC);
    end else if (en) begin
      // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
      pc <= load ? din : pc + PC_W'(inc);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// nic8 fetch/execute sequencer: owns PC and IR, fetches opcode and operand
// bytes from ROM, and gates the decoder with irValid so each instruction
// fires its register triggers exactly once. Provides run/halt/single-step.
// Optional feature macro: RETIRE_COUNT_EN (adds the retired-instruction counter).
module fetch_sequencer
  import nic8_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              resetBar,
  fetch_sequencer_if.master bus
);

  seq_state_t      state;
  logic            step_prev;
  logic            one_shot;
  logic [PC_W-1:0] pc_q;

  logic step_edge;
  logic operand_ok;
  logic fetch_done;
  logic exec_done;

  assign step_edge  = bus.stepReq & ~step_prev;
  assign operand_ok = ~bus.immediate | bus.romReady;
  assign fetch_done = (state == FETCH) & bus.romReady;
  assign exec_done  = (state == EXEC) & operand_ok;

  // NOTE: irValid is deliberately combinational; it must drop in the same
  // cycle the operand byte is not ready, so a registered copy would be late.
  assign bus.irValid = exec_done;
  assign bus.romAddr = pc_q;
  assign bus.pc      = pc_q;

  pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .resetBar (resetBar),
    .en       (fetch_done | exec_done),
    .load     (exec_done & bus.doJump),
    .inc      (fetch_done | bus.immediate),
    .din      (PC_W'(bus.busIn)),
    .pc       (pc_q)
  );

  // Sequencer FSM with registered IR, halted and stepAck
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      state       <= RST;
      bus.ir      <= 8'h00;
      bus.stepAck <= 1'b0;
      bus.halted  <= 1'b0;
      step_prev   <= 1'b0;
      one_shot    <= 1'b0;
    end else begin
      step_prev   <= bus.stepReq;
      bus.stepAck <= 1'b0;
      case (state)
        RST: begin
          if (bus.run) begin
            state <= FETCH;
          end else begin
            state      <= HALT;
            bus.halted <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.romReady) begin
            bus.ir <= bus.romData;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (operand_ok) begin
            if (one_shot || !bus.run) begin
              one_shot   <= 1'b0;
              state      <= HALT;
              bus.halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: begin
          if (bus.run) begin
            // run wins: acknowledge a coincident step but keep running
            state       <= FETCH;
            bus.halted  <= 1'b0;
            bus.stepAck <= step_edge;
          end else if (step_edge) begin
            state       <= FETCH;
            bus.halted  <= 1'b0;
            bus.stepAck <= 1'b1;
            one_shot    <= 1'b1;
          end
        end
        default: state <= RST;
      endcase
    end
  end

`ifdef RETIRE_COUNT_EN
  logic [CNT_W-1:0] retire_count;

  // Count completed instructions, wrapping at 2^CNT_W
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      retire_count <= '0;
    end else if (exec_done) begin
      retire_count <= retire_count + 1'b1;
    end
  end

  assign bus.retireCount = retire_count;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. The bench plays ROM and decoder,
// keeps an instruction-level reference of the sequencer, and compares every
// output each cycle; directed scenarios add hand-computed literal checks.
module tb_fetch_sequencer;
  import nic8_pkg::*;

  localparam int         PC_W  = 8;
  localparam int         CNT_W = 16;
  localparam logic [7:0] REG_A = 8'hA0;  // value a register source drives onto the bus

  logic clk      = 1'b0;
  logic resetBar = 1'b1;

  fetch_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  fetch_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC (0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk      (clk),
    .resetBar (resetBar),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // ROM and decoder
  logic [7:0] rom [256];

  function automatic logic is_imm(input logic [7:0] i);
    return ir_source(i) == SRC_ROM;
  endfunction

  function automatic logic is_jump(input logic [7:0] i);
    return ir_dest(i) == DST_PC;
  endfunction

  assign bus.romData   = rom[bus.romAddr];
  assign bus.immediate = is_imm(bus.ir);
  assign bus.doJump    = is_jump(bus.ir);
  assign bus.busIn     = is_imm(bus.ir) ? bus.romData : REG_A;

  // Bookkeeping
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: instruction-level view of the sequencer
  localparam int IDLE = 0, NEED_OP = 1, NEED_ARG = 2;
  int               m_stage = IDLE;
  logic             m_boot  = 1'b1;
  logic [7:0]       m_pc    = 8'h00;
  logic [7:0]       m_ir    = 8'h00;
  logic             m_halt  = 1'b0;
  logic             m_ack   = 1'b0;
  logic             m_one   = 1'b0;
  logic             m_prev  = 1'b0;
  logic             m_edge;
  logic [7:0]       m_target;
  logic [CNT_W-1:0] m_cnt   = '0;

  always @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      m_boot = 1'b1; m_stage = IDLE; m_pc = 8'h00; m_ir = 8'h00;
      m_halt = 1'b0; m_ack = 1'b0; m_one = 1'b0; m_prev = 1'b0; m_cnt = '0;
    end else begin
      m_edge = bus.stepReq && !m_prev;
      m_ack  = 1'b0;
      if (m_boot) begin
        m_boot  = 1'b0;
        m_stage = bus.run ? NEED_OP : IDLE;
      end else if (m_stage == NEED_OP) begin
        if (bus.romReady) begin
          m_ir    = rom[m_pc];
          m_pc    = m_pc + 8'd1;
          m_stage = NEED_ARG;
        end
      end else if (m_stage == NEED_ARG) begin
        if (!is_imm(m_ir) || bus.romReady) begin
          m_target = is_imm(m_ir) ? rom[m_pc] : REG_A;
          m_pc     = is_jump(m_ir) ? m_target : m_pc + (is_imm(m_ir) ? 8'd1 : 8'd0);
          m_cnt    = m_cnt + 1'b1;
          m_stage  = (m_one || !bus.run) ? IDLE : NEED_OP;
          m_one    = 1'b0;
        end
      end else if (bus.run || m_edge) begin
        m_stage = NEED_OP;
        m_ack   = m_edge;
        m_one   = m_edge && !bus.run;
      end
      m_halt = (m_stage == IDLE);
      m_prev = bus.stepReq;
    end
  end

  function automatic logic exp_valid();
    return !m_boot && m_stage == NEED_ARG && (!is_imm(m_ir) || bus.romReady);
  endfunction

  // Per-cycle compare, sampled away from the active edge
  always @(negedge clk) begin
    #2;
    check("pc",      bus.pc,      m_pc);
    check("romAddr", bus.romAddr, m_pc);
    check("ir",      bus.ir,      m_ir);
    check("irValid", bus.irValid, exp_valid());
    check("halted",  bus.halted,  m_halt);
    check("stepAck", bus.stepAck, m_ack);
`ifdef RETIRE_COUNT_EN
    check("retireCount", bus.retireCount, m_cnt);
`endif
  end

  // Stimulus helpers
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic drive(input logic rdy, input logic stp, input logic rn);
    @(negedge clk);
    bus.romReady = rdy;
    bus.stepReq  = stp;
    bus.run      = rn;
    #2;
  endtask

  task automatic next_retire(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.irValid && n < budget);
    check("retire_within_budget", bus.irValid, 1'b1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_ir [6];
  logic [7:0] exp_pc [6];
  logic       rdy_pat [6];
  int n, pulses, acks, at, halt_cycles;

  initial begin
    // Program loop: 00 A<-#55, 02 PC<-#40, 40 A<-reg, 41 PC<-reg(A0), A0 PC<-#FF, FF A<-reg
    for (int i = 0; i < 256; i++) rom[i] = 8'h21;
    rom[8'h00] = 8'h20; rom[8'h01] = 8'h55;
    rom[8'h02] = 8'h10; rom[8'h03] = 8'h40;
    rom[8'h40] = 8'h21;
    rom[8'h41] = 8'h11;
    rom[8'hA0] = 8'h10; rom[8'hA1] = 8'hFF;
    rom[8'hFF] = 8'h21;
    exp_ir = '{8'h20, 8'h10, 8'h21, 8'h11, 8'h10, 8'h21};
    exp_pc = '{8'h02, 8'h40, 8'h41, 8'hA0, 8'hFF, 8'h00};
    rdy_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    bus.romReady = 1'b1;
    bus.run      = 1'b1;
    bus.stepReq  = 1'b0;
    #1 resetBar = 1'b0;
    tick();
    check("rst_pc",      bus.pc,      8'h00);
    check("rst_ir",      bus.ir,      8'h00);
    check("rst_irValid", bus.irValid, 1'b0);
    check("rst_halted",  bus.halted,  1'b0);
    @(negedge clk) resetBar = 1'b1;

    // Free run through the loop: latency, IR, jumps and PC wrap
    for (int k = 0; k < 6; k++) begin
      next_retire(8, n);
      check("retire_latency", n, (k == 0) ? 2 : 1);
      check("retire_ir", bus.ir, exp_ir[k]);
      tick();
      check("next_pc", bus.pc, exp_pc[k]);
    end

    // ROM waits: 3 in FETCH, 2 in EXEC on an immediate instruction at pc 0
    #1 bus.romReady = 1'b0;
    pulses = 0;
    at = -1;
    for (int j = 0; j < 6; j++) begin
      drive(rdy_pat[j], 1'b0, 1'b1);
      if (bus.irValid) begin
        pulses++;
        at = j;
      end
    end
    check("stall_pulses", pulses, 1);
    check("stall_cycles", at + 2, 7);
    check("stall_ir", bus.ir, 8'h20);
    drive(1'b1, 1'b0, 1'b1);
    check("stall_pc", bus.pc, 8'h02);

    // Drop run mid-instruction: it completes, then HALT
    #1 bus.run = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    check("last_exec", bus.irValid, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    check("halted_after_run_drop", bus.halted, 1'b1);
    check("halt_pc", bus.pc, 8'h40);

    // Single step: stepReq held 5 cycles gives one ack and one instruction
    acks = 0;
    pulses = 0;
    for (int j = 0; j < 6; j++) begin
      drive(1'b1, (j < 5), 1'b0);
      acks += int'(bus.stepAck);
      pulses += int'(bus.irValid);
    end
    check("step_acks", acks, 1);
    check("step_instrs", pulses, 1);
    check("step_halted", bus.halted, 1'b1);
    check("step_pc", bus.pc, 8'h41);

    // Step edges while running are ignored
    drive(1'b1, 1'b0, 1'b1);
    acks = 0;
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, logic'(j % 2), 1'b1);
      acks += int'(bus.stepAck);
    end
    check("run_step_acks", acks, 0);
    check("run_not_halted", bus.halted, 1'b0);

    // Run and step edge together in HALT: acked, and run keeps going
    for (int j = 0; j < 6; j++) drive(1'b1, 1'b0, 1'b0);
    check("halted_again", bus.halted, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    check("run_step_ack", bus.stepAck, 1'b1);
    halt_cycles = 0;
    for (int j = 0; j < 6; j++) begin
      drive(1'b1, 1'b0, 1'b1);
      halt_cycles += int'(bus.halted);
    end
    check("run_wins_no_halt", halt_cycles, 0);

    // Asynchronous reset in the middle of EXEC
    next_retire(8, n);
    #1 resetBar = 1'b0;
    #1;
    check("async_pc",      bus.pc,      8'h00);
    check("async_ir",      bus.ir,      8'h00);
    check("async_irValid", bus.irValid, 1'b0);
    check("async_stepAck", bus.stepAck, 1'b0);
    check("async_halted",  bus.halted,  1'b0);
    tick();
    @(negedge clk) resetBar = 1'b1;

    // Ten instructions from reset
    for (int j = 0; j < 10; j++) next_retire(8, n);
    tick();
    check("ten_instr_pc", bus.pc, 8'hA0);
`ifdef RETIRE_COUNT_EN
    check("retire_ten", bus.retireCount, 16'd10);
`endif
    #1 resetBar = 1'b0;
    #1;
    check("reset_pc_again", bus.pc, 8'h00);
`ifdef RETIRE_COUNT_EN
    check("retire_cleared", bus.retireCount, 16'd0);
`endif
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
